rgb2yuv_frame_sched: RTL and testbench



---
 rtl/rgb2yuv_pkg.sv | 16 +
 rtl/rgb2yuv_frame_sched.sv | 141 ++++++++++++++
 tb/tb_rgb2yuv_frame_sched.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb2yuv_pkg.sv
// Shared types and constants for the RGB-to-YUV frame scheduler
// and the core sequencer that it drives.
package rgb2yuv_pkg;

    localparam int BITS_DEF = 9;
    localparam int CORE_LAT = 11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAUNCH,
        WAIT,
        EMIT
    } state_t;

endpackage

// File: rtl/rgb2yuv_frame_sched.sv
// Frame scheduler: streams pixels through the multi-cycle RGB-to-YUV
// core, one launch per pixel, with a watchdog on each conversion.
module rgb2yuv_frame_sched
    import rgb2yuv_pkg::*;
#(
    parameter int BITS      = BITS_DEF,
    parameter int FRAME_PIX = 64,
    parameter int TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_r,
    input  logic [BITS-1:0] in_g,
    input  logic [BITS-1:0] in_b,
    output logic            core_start,
    output logic [BITS-1:0] core_r,
    output logic [BITS-1:0] core_g,
    output logic [BITS-1:0] core_b,
    input  logic            core_done,
    input  logic [BITS-1:0] core_y,
    input  logic [BITS-1:0] core_u,
    input  logic [BITS-1:0] core_v,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_y,
    output logic [BITS-1:0] out_u,
    output logic [BITS-1:0] out_v,
    output logic            out_last,
    output logic            busy,
    output logic            frame_done,
    output logic            err
);

    localparam int PW = $clog2(FRAME_PIX);
    localparam int WW = $clog2(TIMEOUT);

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_pix_cnt;
    logic [WW-1:0]   r_wd;
    logic            r_err;
    logic            r_frame_done;
    logic [BITS-1:0] r_core_r, r_core_g, r_core_b;
    logic [BITS-1:0] r_out_y, r_out_u, r_out_v;

    logic w_last;
    logic w_wd_exp;
    logic w_start;
    logic w_cap_in;
    logic w_cap_out;
    logic w_abort;
    logic w_fin;
    logic w_adv;

    assign w_last   = (r_pix_cnt == PW'(FRAME_PIX - 1));
    assign w_wd_exp = (r_wd == WW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (frame_start) w_next = FETCH;
            FETCH:   if (in_valid) w_next = LAUNCH;
            LAUNCH:  w_next = WAIT;
            WAIT: begin
                // A completion on the expiry cycle still counts.
                if (core_done)     w_next = EMIT;
                else if (w_wd_exp) w_next = IDLE;
            end
            EMIT:    if (out_ready) w_next = w_last ? IDLE : FETCH;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (r_state == FETCH);
        core_start = (r_state == LAUNCH);
        out_valid  = (r_state == EMIT);
        busy       = (r_state != IDLE);
        out_last   = (r_state == EMIT) && w_last;
        w_start    = (r_state == IDLE) && frame_start;
        w_cap_in   = (r_state == FETCH) && in_valid;
        w_cap_out  = (r_state == WAIT) && core_done;
        w_abort    = (r_state == WAIT) && !core_done && w_wd_exp;
        w_fin      = (r_state == EMIT) && out_ready && w_last;
        w_adv      = (r_state == EMIT) && out_ready && !w_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt    <= '0;
            r_wd         <= '0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
            r_core_r     <= '0;
            r_core_g     <= '0;
            r_core_b     <= '0;
            r_out_y      <= '0;
            r_out_u      <= '0;
            r_out_v      <= '0;
        end else begin
            r_frame_done <= w_abort | w_fin;
            if (w_start) begin
                r_pix_cnt <= '0;
                r_err     <= 1'b0;
            end else begin
                if (w_adv)   r_pix_cnt <= r_pix_cnt + PW'(1);
                if (w_abort) r_err     <= 1'b1;
            end
            if (r_state == LAUNCH)    r_wd <= '0;
            else if (r_state == WAIT) r_wd <= r_wd + WW'(1);
            if (w_cap_in) begin
                r_core_r <= in_r;
                r_core_g <= in_g;
                r_core_b <= in_b;
            end
            if (w_cap_out) begin
                r_out_y <= core_y;
                r_out_u <= core_u;
                r_out_v <= core_v;
            end
        end
    end

    assign core_r     = r_core_r;
    assign core_g     = r_core_g;
    assign core_b     = r_core_b;
    assign out_y      = r_out_y;
    assign out_u      = r_out_u;
    assign out_v      = r_out_v;
    assign err        = r_err;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_rgb2yuv_frame_sched.sv
// Directed bench for rgb2yuv_frame_sched with a behavioural core
// model and an output scoreboard.
module tb_rgb2yuv_frame_sched;
    import rgb2yuv_pkg::*;

    localparam int B  = 9;
    localparam int FP = 4;

    typedef struct packed {
        logic [B-1:0] y;
        logic [B-1:0] u;
        logic [B-1:0] v;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [B-1:0] in_r = '0, in_g = '0, in_b = '0;
    logic         core_start;
    logic [B-1:0] core_r, core_g, core_b;
    logic         core_done;
    logic [B-1:0] core_y, core_u, core_v;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [B-1:0] out_y, out_u, out_v;
    logic         out_last;
    logic         busy;
    logic         frame_done;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int nout    = 0;
    exp_t q[$];

    int           core_lat  = CORE_LAT;
    logic         core_dead = 1'b0;
    logic         spur_done = 1'b0;
    logic         m_done = 1'b0;
    logic [B-1:0] m_y = '0, m_u = '0, m_v = '0;
    int           cd = 0;

    rgb2yuv_frame_sched #(
        .BITS(B), .FRAME_PIX(FP), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .core_start(core_start),
        .core_r(core_r), .core_g(core_g), .core_b(core_b),
        .core_done(core_done),
        .core_y(core_y), .core_u(core_u), .core_v(core_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_u(out_u), .out_v(out_v),
        .out_last(out_last), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [B-1:0] fy(input logic [B-1:0] r, g);
        return r ^ g;
    endfunction
    function automatic logic [B-1:0] fu(input logic [B-1:0] g, b);
        return g + b;
    endfunction
    function automatic logic [B-1:0] fv(input logic [B-1:0] r, b);
        return b - r;
    endfunction

    // Core model: done pulse core_lat cycles after the sampled start.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            cd <= 0;
        end else if (core_start && !core_dead) begin
            cd <= core_lat - 1;
        end else if (cd > 0) begin
            cd <= cd - 1;
            if (cd == 1) begin
                m_done <= 1'b1;
                m_y    <= fy(core_r, core_g);
                m_u    <= fu(core_g, core_b);
                m_v    <= fv(core_r, core_b);
            end
        end
    end
    assign core_done = m_done | spur_done;
    assign core_y = m_y;
    assign core_u = m_u;
    assign core_v = m_v;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_empty", 32'(q.size()), 32'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_y", 32'(out_y), 32'(e.y));
                chk("out_u", 32'(out_u), 32'(e.u));
                chk("out_v", 32'(out_v), 32'(e.v));
                chk("out_last", 32'(out_last), 32'(e.last));
                nout++;
            end
        end
        if (frame_done) chk("fd_no_ov", 32'(out_valid), 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send(input logic [B-1:0] r, g, b,
                        input logic last, output int t);
        exp_t e;
        int   n;
        n = 0;
        in_r = r;
        in_g = g;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("in_hs", 32'(in_ready), 32'd1);
        t = cyc;
        e.y = fy(r, g);
        e.u = fu(g, b);
        e.v = fv(r, b);
        e.last = last;
        q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_fd(output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("fd_seen", 32'(frame_done), 32'd1);
        t = cyc;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_inrdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_cst"}, 32'(core_start), 32'd0);
        chk({tag, "_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_oy"}, 32'(out_y), 32'd0);
        chk({tag, "_cr"}, 32'(core_r), 32'd0);
    endtask

    initial begin
        int t0, t1, tl;
        logic [B-1:0] hy, hu, hv;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst");

        // Smoke frame
        nout = 0;
        pulse_start();
        send(9'd255, 9'd0, 9'd0, 1'b0, t0);
        send(9'd0, 9'd255, 9'd0, 1'b0, t1);
        send(9'd0, 9'd0, 9'd255, 1'b0, t1);
        send(9'd128, 9'd128, 9'd128, 1'b1, t1);
        wait_fd(t1);
        chk("smoke_cycles", 32'(t1 - t0), 32'd56);
        chk("smoke_nout", 32'(nout), 32'd4);
        chk("smoke_err", 32'(err), 32'd0);
        chk("smoke_busy", 32'(busy), 32'd0);

        // Backpressure
        nout = 0;
        out_ready = 1'b0;
        pulse_start();
        send(9'd10, 9'd20, 9'd30, 1'b0, t0);
        t1 = 0;
        @(negedge clk);
        while (!out_valid && t1 < 100) begin
            @(negedge clk);
            t1++;
        end
        chk("bp_ov", 32'(out_valid), 32'd1);
        hy = out_y;
        hu = out_u;
        hv = out_v;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_y", 32'(out_y), 32'(hy));
            chk("bp_u", 32'(out_u), 32'(hu));
            chk("bp_v", 32'(out_v), 32'(hv));
            chk("bp_inrdy", 32'(in_ready), 32'd0);
            chk("bp_cst", 32'(core_start), 32'd0);
            chk("bp_ovh", 32'(out_valid), 32'd1);
        end
        tick();
        out_ready = 1'b1;
        send(9'd1, 9'd2, 9'd3, 1'b0, t1);
        send(9'd4, 9'd5, 9'd6, 1'b0, t1);
        send(9'd7, 9'd8, 9'd9, 1'b1, t1);
        wait_fd(t1);
        chk("bp_nout", 32'(nout), 32'd4);

        // Spurious frame_start in WAIT, core_done in FETCH
        nout = 0;
        pulse_start();
        send(9'd300, 9'd12, 9'd77, 1'b0, t0);
        repeat (3) tick();
        frame_start = 1'b1;
        @(negedge clk);
        chk("sp_fs_busy", 32'(busy), 32'd1);
        chk("sp_fs_inrdy", 32'(in_ready), 32'd0);
        tick();
        frame_start = 1'b0;
        @(negedge clk);
        chk("sp_fs_cst", 32'(core_start), 32'd0);
        t1 = 0;
        while (!in_ready && t1 < 100) begin
            @(negedge clk);
            t1++;
        end
        chk("sp_fetch", 32'(in_ready), 32'd1);
        tick();
        spur_done = 1'b1;
        @(negedge clk);
        chk("sp_cd_inrdy", 32'(in_ready), 32'd1);
        chk("sp_cd_ov", 32'(out_valid), 32'd0);
        tick();
        spur_done = 1'b0;
        @(negedge clk);
        chk("sp_cd_inrdy2", 32'(in_ready), 32'd1);
        chk("sp_cd_cst", 32'(core_start), 32'd0);
        tick();
        send(9'd33, 9'd44, 9'd55, 1'b0, t1);
        send(9'd66, 9'd77, 9'd88, 1'b0, t1);
        send(9'd99, 9'd111, 9'd222, 1'b1, t1);
        wait_fd(t1);
        chk("sp_nout", 32'(nout), 32'd4);

        // Done on the final watchdog cycle
        nout = 0;
        core_lat = 16;
        pulse_start();
        send(9'd5, 9'd6, 9'd7, 1'b0, t0);
        send(9'd8, 9'd9, 9'd10, 1'b0, t1);
        send(9'd11, 9'd12, 9'd13, 1'b0, t1);
        send(9'd14, 9'd15, 9'd16, 1'b1, t1);
        wait_fd(t1);
        chk("tie_nout", 32'(nout), 32'd4);
        chk("tie_err", 32'(err), 32'd0);
        core_lat = CORE_LAT;

        // Watchdog abort
        core_dead = 1'b1;
        pulse_start();
        send(9'd1, 9'd1, 9'd1, 1'b0, t0);
        @(negedge clk);
        chk("wd_cst", 32'(core_start), 32'd1);
        tl = cyc;
        wait_fd(t1);
        chk("wd_cycles", 32'(t1 - tl), 32'd17);
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_busy", 32'(busy), 32'd0);
        q.delete();
        core_dead = 1'b0;
        tick();
        chk("wd_err_hold", 32'(err), 32'd1);
        pulse_start();
        @(negedge clk);
        chk("wd_err_clr", 32'(err), 32'd0);
        chk("wd_fetch", 32'(in_ready), 32'd1);

        // Reset in WAIT of the second pixel
        nout = 0;
        tick();
        send(9'd20, 9'd40, 9'd60, 1'b0, t0);
        send(9'd80, 9'd100, 9'd120, 1'b0, t0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        check_idle("mrst");
        chk("mrst_nout", 32'(nout), 32'd1);
        nout = 0;
        pulse_start();
        send(9'd21, 9'd22, 9'd23, 1'b0, t0);
        send(9'd24, 9'd25, 9'd26, 1'b0, t1);
        send(9'd27, 9'd28, 9'd29, 1'b0, t1);
        send(9'd30, 9'd31, 9'd32, 1'b1, t1);
        wait_fd(t1);
        chk("post_cycles", 32'(t1 - t0), 32'd56);
        chk("post_nout", 32'(nout), 32'd4);
        chk("post_err", 32'(err), 32'd0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
